vga_timing_core: RTL and testbench
==================================

// Module: vga_timing_core
// PURPOSE
// - 640x480@60 VGA timing generator and colour-bar source, driven from the 50 MHz board clock.
// - Internally derives a 25 MHz pixel enable, then horizontal/vertical counters, active-low syncs and 8-bit RGB DAC data.
// - Sits between the board clock/reset and the VGA DAC pins; exports line/frame ticks for downstream frame logic.
// - Single clock domain (clk_50); the pixel rate is a clock enable, never a derived clock.
// PARAMETERS
// - H_ACTIVE 640 visible pixels per line
// - H_FP 16 horizontal front porch (pixels)
// - H_SYNC 96 horizontal sync width (pixels)
// - H_BP 48 horizontal back porch (pixels); H_TOTAL = 800
// - V_ACTIVE 480 visible lines
// - V_FP 10 vertical front porch (lines)
// - V_SYNC 2 vertical sync width (lines)
// - V_BP 33 vertical back porch (lines); V_TOTAL = 525
// PORTS
// - clk_50      in   1   50 MHz system clock; every flop is clocked on its rising edge
// - reset       in   1   async, active-low reset: asserting (0) clears immediately; release is sampled on clk_50
// - pix_en      out  1   pixel enable: high every 2nd clk_50 cycle (25 MHz rate)
// - line_tick   out  1   1-clk pulse when pix_en=1 and h_cnt=799 (end of line)
// - frame_tick  out  1   1-clk pulse when line_tick=1 and v_cnt=524
// - h_cnt       out  10  current pixel column, 0..799
// - v_cnt       out  10  current line, 0..524
// - h_sync      out  1   horizontal sync, active low
// - v_sync      out  1   vertical sync, active low
// - R_dac       out  8   red DAC value
// - G_dac       out  8   green DAC value
// - B_dac       out  8   blue DAC value
// BEHAVIOUR
// - Reset values (reset=0):
//   - pix_en=0, h_cnt=0, v_cnt=0, line_tick=0, frame_tick=0
//   - h_sync=1, v_sync=1, R/G/B_dac=0
// - pix_en: toggle flop; the first high cycle is the 2nd clk_50 edge after reset release, then it alternates 0/1.
// - h_cnt advances by 1 only on cycles with pix_en=1; 799 wraps to 0.
// - v_cnt advances by 1 only when h_cnt wraps (line_tick); 524 wraps to 0.
// - h_cnt and v_cnt never hold out-of-range values.
// - Decode of the current counters, all registered, so these outputs lag the counters by one clk_50:
//   - h_sync = 0 for h_cnt in 656..751, else 1
//   - v_sync = 0 for v_cnt in 490..491, else 1
//   - active = (h_cnt<640) && (v_cnt<480); outside active, R/G/B = 0
// - Colour bars inside active, selected by column band of 80 pixels each (channel = 8'hFF or 8'h00):
//   - 0-79 white (FF,FF,FF); 80-159 yellow (FF,FF,00); 160-239 cyan (00,FF,FF); 240-319 green (00,FF,00)
//   - 320-399 magenta (FF,00,FF); 400-479 red (FF,00,00); 480-559 blue (00,00,FF); 560-639 black (00,00,00)
// - Periods: line = 800 pixels = 1600 clk_50; frame = 525 lines = 840000 clk_50.
// - Mid-operation reset forces all reset values asynchronously; timing restarts from h_cnt=0, v_cnt=0.
// TESTING
// - Reset behaviour: hold reset=0 for 3 clks -> all outputs at reset values; release -> pix_en pattern 0,1,0,1 starting on the 2nd edge.
// - Horizontal timing: run 10 lines -> h_sync low for 192 clk_50 every 1600 clk_50; falling edge 1 clk after h_cnt becomes 656.
// - Vertical timing: run >1 frame -> v_sync low for 3200 clk_50 every 840000 clk_50; line_tick spacing 1600; frame_tick spacing 840000.
// - Colour bars: on line v_cnt=100, sample RGB at h_cnt=0 -> FF,FF,FF; h_cnt=400 -> FF,00,00; h_cnt=500 -> 00,00,FF; h_cnt=700 -> 0,0,0.
// - Vertical blanking: at v_cnt=500, any h_cnt -> RGB=0.
// - Reset mid-frame: assert reset at v_cnt=300 -> counters 0 immediately; after release, first v_sync falling edge 490 lines later.

Source files
------------

// File: rtl/vga_timing_core_if.sv
// VGA pin-side bundle: pixel enable, line/frame ticks, counters, syncs and DAC data.
// The timing core drives the master side; display or frame logic observes through slave.
interface vga_timing_core_if;
  logic       pix_en;
  logic       line_tick;
  logic       frame_tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_sync;
  logic       v_sync;
  logic [7:0] R_dac;
  logic [7:0] G_dac;
  logic [7:0] B_dac;

  modport master (
    output pix_en, line_tick, frame_tick, h_cnt, v_cnt,
           h_sync, v_sync, R_dac, G_dac, B_dac
  );

  modport slave (
    input  pix_en, line_tick, frame_tick, h_cnt, v_cnt,
           h_sync, v_sync, R_dac, G_dac, B_dac
  );
endinterface

// File: rtl/vga_timing_core.sv
// 640x480@60 VGA timing generator and 8-band colour-bar source on the 50 MHz clock.
// The pixel rate is a clock enable; the sync and RGB outputs are registered one clk_50 behind the counters.
module vga_timing_core #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic         clk_50,
  input  logic         reset,
  vga_timing_core_if.master vga
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam int unsigned BAND_W  = H_ACTIVE / 8;

  logic       run_q;
  logic       pix_en_q;
  logic [9:0] h_q, v_q;
  logic       h_end, v_end;
  logic       hs_n, vs_n, active;
  logic [2:0] band;
  logic       hs_q, vs_q;
  logic [7:0] r_q, g_q, b_q;

  // run_q delays the toggle by one edge so the first enable lands on the 2nd edge after release.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      run_q    <= 1'b0;
      pix_en_q <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      pix_en_q <= run_q & ~pix_en_q;
    end
  end

  always_comb begin
    h_end = pix_en_q && (h_q == H_LAST);
    v_end = (v_q == V_LAST);
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      if (pix_en_q) h_q <= h_end ? '0 : h_q + 10'd1;
      if (h_end)    v_q <= v_end ? '0 : v_q + 10'd1;
    end
  end

  always_comb begin
    hs_n   = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    vs_n   = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    active = (h_q < H_VIS) && (v_q < V_VIS);
    band   = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (h_q >= 10'(i * BAND_W)) band = 3'(i);
    end
  end

  // Band index bits map directly onto channels: red off in bands 2,3,6,7, green off in 4..7, blue off in odd bands.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      hs_q <= hs_n;
      vs_q <= vs_n;
      r_q  <= {8{active & ~band[1]}};
      g_q  <= {8{active & ~band[2]}};
      b_q  <= {8{active & ~band[0]}};
    end
  end

  assign vga.pix_en     = pix_en_q;
  assign vga.line_tick  = h_end;
  assign vga.frame_tick = h_end & v_end;
  assign vga.h_cnt      = h_q;
  assign vga.v_cnt      = v_q;
  assign vga.h_sync     = hs_q;
  assign vga.v_sync     = vs_q;
  assign vga.R_dac      = r_q;
  assign vga.G_dac      = g_q;
  assign vga.B_dac      = b_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench for vga_timing_core; vertical geometry shrunk to 16 lines (10 active, sync on lines 12-13)
// so two frames and a mid-frame reset fit in a short run, horizontal geometry left at 640/800.
module tb_vga_timing_core;

  logic clk_50 = 1'b0;
  logic reset  = 1'b0;

  always #10 clk_50 = ~clk_50;

  vga_timing_core_if vif ();

  vga_timing_core #(
    .V_ACTIVE (10),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2)
  ) u_dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .vga    (vif.master)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample time t (edges since release) -> expected RGB; RGB at t reflects counters at t-1.
  localparam int NCOL = 15;
  int unsigned col_t   [NCOL] = '{8002, 8160, 8162, 8402, 8602, 8702, 8802, 9002, 9120, 9122,
                                  9282, 9402, 14402, 16002, 22402};
  logic [23:0] col_rgb [NCOL] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h0000FF, 24'h000000,
                                  24'h000000, 24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000};

  initial begin
    int unsigned t;
    int unsigned hs_low10, hs_fall10, hs_first, hs_first_h, hs_prev_fall, hs_sp_err;
    int unsigned lt_cnt, lt_first, lt_prev, lt_sp_err;
    int unsigned ft_cnt, ft_first, ft_prev, ft_sp_err;
    int unsigned vs_low, vs_fall, vs_first, vs_first_v, vs_prev_fall, vs_sp_err;
    int unsigned vs_after;
    logic prev_hs, prev_vs;

    hs_low10 = 0; hs_fall10 = 0; hs_first = 0; hs_first_h = 0; hs_prev_fall = 0; hs_sp_err = 0;
    lt_cnt = 0; lt_first = 0; lt_prev = 0; lt_sp_err = 0;
    ft_cnt = 0; ft_first = 0; ft_prev = 0; ft_sp_err = 0;
    vs_low = 0; vs_fall = 0; vs_first = 0; vs_first_v = 0; vs_prev_fall = 0; vs_sp_err = 0;
    vs_after = 0;

    reset = 1'b0;
    repeat (3) @(posedge clk_50);
    #1;
    check("rst_pix_en", 32'(vif.pix_en), 32'd0);
    check("rst_h_cnt", 32'(vif.h_cnt), 32'd0);
    check("rst_v_cnt", 32'(vif.v_cnt), 32'd0);
    check("rst_line_tick", 32'(vif.line_tick), 32'd0);
    check("rst_frame_tick", 32'(vif.frame_tick), 32'd0);
    check("rst_h_sync", 32'(vif.h_sync), 32'd1);
    check("rst_v_sync", 32'(vif.v_sync), 32'd1);
    check("rst_rgb", 32'({vif.R_dac, vif.G_dac, vif.B_dac}), 32'd0);

    @(negedge clk_50);
    reset = 1'b1;
    prev_hs = 1'b1;
    prev_vs = 1'b1;

    for (t = 1; t <= 51300; t++) begin
      @(posedge clk_50);
      #1;
      if (t <= 4) check($sformatf("pix_en_t%0d", t), 32'(vif.pix_en), 32'((t % 2) == 0));
      if (t == 4) check("h_cnt_t4", 32'(vif.h_cnt), 32'd1);
      if (t == 9402) begin
        check("h_cnt_t9402", 32'(vif.h_cnt), 32'd700);
        check("v_cnt_t9402", 32'(vif.v_cnt), 32'd5);
      end
      for (int i = 0; i < NCOL; i++)
        if (t == col_t[i])
          check($sformatf("rgb_t%0d", t), 32'({vif.R_dac, vif.G_dac, vif.B_dac}), 32'(col_rgb[i]));

      if (prev_hs && !vif.h_sync) begin
        if (hs_first == 0) begin
          hs_first   = t;
          hs_first_h = 32'(vif.h_cnt);
        end else if (t - hs_prev_fall != 1600) hs_sp_err++;
        hs_prev_fall = t;
        if (t <= 16001) hs_fall10++;
      end
      if (!vif.h_sync && t <= 16001) hs_low10++;
      prev_hs = vif.h_sync;

      if (vif.line_tick) begin
        if (lt_cnt == 0) lt_first = t;
        else if (t - lt_prev != 1600) lt_sp_err++;
        lt_prev = t;
        lt_cnt++;
      end
      if (vif.frame_tick) begin
        if (ft_cnt == 0) ft_first = t;
        else if (t - ft_prev != 25600) ft_sp_err++;
        ft_prev = t;
        ft_cnt++;
      end

      if (prev_vs && !vif.v_sync) begin
        if (vs_fall == 0) begin
          vs_first   = t;
          vs_first_v = 32'(vif.v_cnt);
        end else if (t - vs_prev_fall != 25600) vs_sp_err++;
        vs_prev_fall = t;
        vs_fall++;
      end
      if (!vif.v_sync) vs_low++;
      prev_vs = vif.v_sync;
    end

    check("hs_first_fall_t", hs_first, 32'd1314);
    check("hs_first_fall_hcnt", hs_first_h, 32'd656);
    check("hs_low_10lines", hs_low10, 32'd1920);
    check("hs_falls_10lines", hs_fall10, 32'd10);
    check("hs_spacing_err", hs_sp_err, 32'd0);
    check("lt_first_t", lt_first, 32'd1600);
    check("lt_count", lt_cnt, 32'd32);
    check("lt_spacing_err", lt_sp_err, 32'd0);
    check("ft_first_t", ft_first, 32'd25600);
    check("ft_count", ft_cnt, 32'd2);
    check("ft_spacing_err", ft_sp_err, 32'd0);
    check("vs_first_fall_t", vs_first, 32'd19202);
    check("vs_first_fall_vcnt", vs_first_v, 32'd12);
    check("vs_low_2frames", vs_low, 32'd6400);
    check("vs_falls", vs_fall, 32'd2);
    check("vs_spacing_err", vs_sp_err, 32'd0);

    // Run into frame 3, line 6, then pull reset between clock edges.
    for (t = 51301; t <= 60900; t++) @(posedge clk_50);
    #1;
    check("pre_rst_v_cnt", 32'(vif.v_cnt), 32'd6);
    #2 reset = 1'b0;
    #2;
    check("mid_rst_h_cnt", 32'(vif.h_cnt), 32'd0);
    check("mid_rst_v_cnt", 32'(vif.v_cnt), 32'd0);
    check("mid_rst_pix_en", 32'(vif.pix_en), 32'd0);
    check("mid_rst_v_sync", 32'(vif.v_sync), 32'd1);
    repeat (2) @(posedge clk_50);
    @(negedge clk_50);
    reset = 1'b1;
    prev_vs = 1'b1;
    for (t = 1; t <= 25000 && vs_after == 0; t++) begin
      @(posedge clk_50);
      #1;
      if (t == 2) check("post_rst_pix_en_t2", 32'(vif.pix_en), 32'd1);
      if (prev_vs && !vif.v_sync) vs_after = t;
      prev_vs = vif.v_sync;
    end
    check("post_rst_vs_fall_t", vs_after, 32'd19202);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
